mux_n_sel_pipe: RTL and testbench

- Parametrised N-channel, W-bit selector with a registered output stage and valid/ready handshakes on every input and on the output.
- Two modes:
  - Fixed-select: external `sel` picks the channel.
  - Round-robin: internal rotating pointer grants valid channels fairly.
- Sits between key/data-schedule producers and downstream round logic. Replaces the hard-wired 4:1 combinational selectors of 28-bit words.

---
 rtl/mux_pkg.sv | 14 +
 rtl/rr_arbiter_n.sv | 39 +++
 rtl/mux_n_sel_pipe.sv | 87 ++++++++
 tb/tb_mux_n_sel_pipe.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the channel selector: default word width, index
// typedef and a clog2 helper that never returns zero.
package mux_pkg;

   localparam int KEY_HALF_W = 28;
   localparam int MAX_SW     = 4;

   typedef logic [MAX_SW-1:0] ch_idx_t;

   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr, wrapping modulo N.
module rr_arbiter_n
   import mux_pkg::*;
#(
   parameter  int N  = 4,
   localparam int SW = clog2_min1(N)
) (
   input  logic [N-1:0]  req,
   input  logic [SW-1:0] ptr,
   output logic [SW-1:0] grant,
   output logic          found
);

   logic [N-1:0] rot;
   ch_idx_t      offs;
   int           sum;

   // bit j of rot is req[(ptr + j) mod N]
   assign rot = N'({req, req} >> ptr);

   // NOTE: every variable gets a default at the top of the block so no path
   // leaves it unassigned, which would infer a latch.
   always_comb begin
      found = 1'b0;
      offs  = '0;
      sum   = 0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) begin
            found = 1'b1;
            offs  = ch_idx_t'(i);
         end
      end
      sum = int'(ptr) + int'(offs);
      if (sum >= N) sum = sum - N;
      grant = SW'(sum);
   end

endmodule

// File: rtl/mux_n_sel_pipe.sv
// N-channel W-bit selector with a single registered output stage, valid/ready
// handshakes, and fixed-select or round-robin channel choice.
module mux_n_sel_pipe
   import mux_pkg::*;
#(
   parameter  int W  = KEY_HALF_W,
   parameter  int N  = 4,
   localparam int SW = clog2_min1(N)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N*W-1:0]  in_data,
   input  logic [N-1:0]    in_valid,
   output logic [N-1:0]    in_ready,
   input  logic [SW-1:0]   sel,
   input  logic            rr_en,
   output logic [W-1:0]    out_data,
   output logic [SW-1:0]   out_ch,
   output logic            out_valid,
   input  logic            out_ready
);

   logic [SW-1:0] ptr;
   logic [SW-1:0] ptr_next;
   logic [SW-1:0] rr_grant;
   logic          rr_found;
   logic          fixed_found;
   logic [SW-1:0] grant;
   logic          found;
   logic          ld;
   logic [W-1:0]  sel_data;

   rr_arbiter_n #(.N(N)) u_arb (
      .req   (in_valid),
      .ptr   (ptr),
      .grant (rr_grant),
      .found (rr_found)
   );

   assign ld = !out_valid || out_ready;

   // A sel beyond N-1 matches no channel, so it simply never finds a request.
   always_comb begin
      fixed_found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (int'(sel) == i) fixed_found = in_valid[i];
      end
   end

   assign grant = rr_en ? rr_grant : sel;
   assign found = rr_en ? rr_found : fixed_found;

   // in_ready is held low while reset is asserted even though ld is high then.
   always_comb begin
      in_ready = '0;
      sel_data = '0;
      for (int i = 0; i < N; i++) begin
         if (int'(grant) == i) begin
            in_ready[i] = ld && found && rst_n;
            sel_data    = in_data[i*W +: W];
         end
      end
   end

   assign ptr_next = (int'(grant) == N - 1) ? '0 : grant + SW'(1);

   // NOTE: state registers use non-blocking assignments so every register
   // samples pre-edge values regardless of evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         ptr       <= '0;
      end else if (ld) begin
         if (found) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_ch    <= grant;
            if (rr_en) ptr <= ptr_next;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mux_n_sel_pipe.sv
// Scoreboard bench for mux_n_sel_pipe: a 4x28 instance and a 3x8 instance
// driven with directed vectors; monitors pop expected words on each output handshake.
module tb_mux_n_sel_pipe;

   typedef struct {
      logic [31:0] data;
      logic [31:0] ch;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // instance A: N=4, W=28
   logic [27:0]  da [4];
   logic [111:0] in_data_a;
   logic [3:0]   in_valid_a, in_ready_a;
   logic [1:0]   sel_a, out_ch_a;
   logic         rr_en_a, out_valid_a, out_ready_a;
   logic [27:0]  out_data_a;
   assign in_data_a = {da[3], da[2], da[1], da[0]};

   // instance B: N=3, W=8
   logic [7:0]   db [3];
   logic [23:0]  in_data_b;
   logic [2:0]   in_valid_b, in_ready_b;
   logic [1:0]   sel_b, out_ch_b;
   logic         rr_en_b, out_valid_b, out_ready_b;
   logic [7:0]   out_data_b;
   assign in_data_b = {db[2], db[1], db[0]};

   mux_n_sel_pipe #(.W(28), .N(4)) u_dut_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data_a),
      .in_valid  (in_valid_a),
      .in_ready  (in_ready_a),
      .sel       (sel_a),
      .rr_en     (rr_en_a),
      .out_data  (out_data_a),
      .out_ch    (out_ch_a),
      .out_valid (out_valid_a),
      .out_ready (out_ready_a)
   );

   mux_n_sel_pipe #(.W(8), .N(3)) u_dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data_b),
      .in_valid  (in_valid_b),
      .in_ready  (in_ready_b),
      .sel       (sel_b),
      .rr_en     (rr_en_b),
      .out_data  (out_data_b),
      .out_ch    (out_ch_b),
      .out_valid (out_valid_b),
      .out_ready (out_ready_b)
   );

   int   errors = 0;
   int   checks = 0;
   exp_t q_a[$];
   exp_t q_b[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle of stimulus on A just after the edge, check in_ready at the negedge.
   task automatic step_a(input bit rr, input logic [1:0] s, input logic [3:0] v, input bit rdy,
                         input logic [3:0] exp_rdy, input bit push, input logic [31:0] exp_d,
                         input logic [31:0] exp_c, input string name);
      exp_t e;
      @(posedge clk);
      #2;
      rr_en_a     = rr;
      sel_a       = s;
      in_valid_a  = v;
      out_ready_a = rdy;
      if (push) begin
         e.data = exp_d;
         e.ch   = exp_c;
         q_a.push_back(e);
      end
      @(negedge clk);
      check(name, 32'(in_ready_a), 32'(exp_rdy));
   endtask

   task automatic step_b(input bit rr, input logic [1:0] s, input logic [2:0] v, input bit rdy,
                         input logic [2:0] exp_rdy, input bit push, input logic [31:0] exp_d,
                         input logic [31:0] exp_c, input string name);
      exp_t e;
      @(posedge clk);
      #2;
      rr_en_b     = rr;
      sel_b       = s;
      in_valid_b  = v;
      out_ready_b = rdy;
      if (push) begin
         e.data = exp_d;
         e.ch   = exp_c;
         q_b.push_back(e);
      end
      @(negedge clk);
      check(name, 32'(in_ready_b), 32'(exp_rdy));
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1 && out_valid_a && out_ready_a) begin
         if (q_a.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL a_unexpected_word: got ch %0d data %0h with nothing expected", out_ch_a, out_data_a);
         end else begin
            e = q_a.pop_front();
            check("a_out_data", 32'(out_data_a), e.data);
            check("a_out_ch", 32'(out_ch_a), e.ch);
         end
      end
      if (rst_n === 1'b1 && out_valid_b && out_ready_b) begin
         if (q_b.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL b_unexpected_word: got ch %0d data %0h with nothing expected", out_ch_b, out_data_b);
         end else begin
            e = q_b.pop_front();
            check("b_out_data", 32'(out_data_b), e.data);
            check("b_out_ch", 32'(out_ch_b), e.ch);
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) da[i] = '0;
      db[0] = 8'h11; db[1] = 8'h22; db[2] = 8'h33;
      rr_en_a = 1'b0; sel_a = 2'd0; in_valid_a = 4'b1111; out_ready_a = 1'b1;
      rr_en_b = 1'b0; sel_b = 2'd0; in_valid_b = 3'b111;  out_ready_b = 1'b1;

      // reset held for three cycles with requests pending
      repeat (3) @(negedge clk);
      check("rst_out_valid", 32'(out_valid_a), 32'd0);
      check("rst_out_data", 32'(out_data_a), 32'd0);
      check("rst_out_ch", 32'(out_ch_a), 32'd0);
      check("rst_in_ready", 32'(in_ready_a), 32'd0);
      check("rst_in_ready_b", 32'(in_ready_b), 32'd0);
      in_valid_a = '0;
      in_valid_b = '0;
      rst_n = 1'b1;

      // fixed select of channel 2
      da[2] = 28'h0ABCDEF;
      step_a(1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 32'h0ABCDEF, 2, "fix_in_ready");
      step_a(1'b0, 2'd2, 4'b0000, 1'b1, 4'b0000, 1'b0, 0, 0, "fix_idle_ready");
      check("fix_latency_valid", 32'(out_valid_a), 32'd1);

      // round-robin fairness with all channels requesting
      for (int i = 0; i < 4; i++) da[i] = 28'(i + 1);
      for (int k = 0; k < 8; k++) begin
         step_a(1'b1, 2'd0, 4'b1111, 1'b1, 4'(1 << (k % 4)), 1'b1, 32'((k % 4) + 1), 32'(k % 4), "rr_fair_ready");
         if (k == 0) begin
            check("bubble_valid", 32'(out_valid_a), 32'd0);
            check("bubble_data_hold", 32'(out_data_a), 32'h0ABCDEF);
            check("bubble_ch_hold", 32'(out_ch_a), 32'd2);
         end else begin
            check("rr_no_bubble", 32'(out_valid_a), 32'd1);
         end
      end

      // skip and wrap: ptr 0 -> grant 2 -> ptr 3 -> grant 1 -> grant 3 -> ptr 0
      step_a(1'b1, 2'd0, 4'b0100, 1'b1, 4'b0100, 1'b1, 32'd3, 2, "rr_to_ptr3");
      step_a(1'b1, 2'd0, 4'b0010, 1'b1, 4'b0010, 1'b1, 32'd2, 1, "rr_skip_wrap");
      step_a(1'b1, 2'd0, 4'b1000, 1'b1, 4'b1000, 1'b1, 32'd4, 3, "rr_skip_fwd");
      step_a(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 32'd1, 0, "rr_ptr_wrapped");

      // backpressure: word ch0 held for five cycles
      for (int k = 0; k < 5; k++) begin
         step_a(1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b0, 0, 0, "bp_in_ready");
         check("bp_valid", 32'(out_valid_a), 32'd1);
         check("bp_data_stable", 32'(out_data_a), 32'd1);
         check("bp_ch_stable", 32'(out_ch_a), 32'd0);
      end
      step_a(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 32'd2, 1, "bp_release");

      // fixed mode leaves ptr (2) untouched
      step_a(1'b0, 2'd3, 4'b1111, 1'b1, 4'b1000, 1'b1, 32'd4, 3, "mode_fixed");
      step_a(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 32'd3, 2, "mode_rr_ptr_kept");
      step_a(1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 32'd4, 3, "rr_ch3");
      step_a(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 32'd1, 0, "rr_ch0");
      step_a(1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b0, 0, 0, "hold_before_rst");

      // asynchronous reset pulse between edges while a word is held
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      q_a.delete();
      #1;
      check("mid_rst_valid", 32'(out_valid_a), 32'd0);
      check("mid_rst_data", 32'(out_data_a), 32'd0);
      check("mid_rst_ch", 32'(out_ch_a), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready_a), 32'd0);
      in_valid_a = '0;
      rst_n = 1'b1;
      step_a(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 32'd1, 0, "post_rst_grant0");
      step_a(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 0, 0, "a_drain");
      step_a(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 0, 0, "a_idle");
      check("a_sb_empty", 32'(q_a.size()), 32'd0);

      // N=3: out-of-range select and non-power-of-2 wrap
      step_b(1'b0, 2'd1, 3'b111, 1'b1, 3'b010, 1'b1, 32'h22, 1, "b_fix_sel1");
      step_b(1'b0, 2'd3, 3'b111, 1'b1, 3'b000, 1'b0, 0, 0, "b_sel_oor");
      check("b_word_present", 32'(out_valid_b), 32'd1);
      step_b(1'b0, 2'd3, 3'b111, 1'b1, 3'b000, 1'b0, 0, 0, "b_sel_oor2");
      check("b_valid_fell", 32'(out_valid_b), 32'd0);
      check("b_data_hold", 32'(out_data_b), 32'h22);
      step_b(1'b1, 2'd0, 3'b100, 1'b1, 3'b100, 1'b1, 32'h33, 2, "b_rr_ch2");
      step_b(1'b1, 2'd0, 3'b111, 1'b1, 3'b001, 1'b1, 32'h11, 0, "b_rr_wrap0");
      step_b(1'b1, 2'd0, 3'b000, 1'b1, 3'b000, 1'b0, 0, 0, "b_drain");
      step_b(1'b1, 2'd0, 3'b000, 1'b1, 3'b000, 1'b0, 0, 0, "b_idle");
      check("b_sb_empty", 32'(q_b.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
